mem_store_buffer: RTL and testbench

//  Posted-write FIFO between the MEM pipeline stage and the word-addressed data memory.

---
 rtl/mem_store_buffer_if.sv | 40 ++++
 rtl/mem_store_buffer.sv | 110 +++++++++++
 tb/tb_mem_store_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_if.sv
// Bundle of store, load-lookup and data-memory write signals for mem_store_buffer.
// The pipeline/memory side uses the master modport; the buffer uses slave.
interface mem_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;

    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              ld_stall;

    logic              dm_grant;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_write_address;
    logic [DATA_W-1:0] dm_write_data;

    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output st_valid, st_addr, st_data, ld_en, ld_addr, dm_grant,
        input  st_ready, ld_hit, ld_data, ld_stall, dm_write,
               dm_write_address, dm_write_data, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_en, ld_addr, dm_grant,
        output st_ready, ld_hit, ld_data, ld_stall, dm_write,
               dm_write_address, dm_write_data, empty, count
    );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-write FIFO between MEM stage and data memory, with load lookup.
// Define STORE_BUF_FWD_EN to forward buffered data; otherwise matching loads stall.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_store_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Word-granular compare: byte offset bits are ignored.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DEPTH-1:0]  valid_reg;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic full;
    logic is_empty;
    logic push;
    logic pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);
    assign push     = bus.st_valid && !full;
    assign pop      = !is_empty && bus.dm_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
            // Push and pop never hit the same slot: push needs !full, pop needs !empty.
            if (pop)
                valid_reg[rd_ptr_reg] <= 1'b0;
            if (push)
                valid_reg[wr_ptr_reg] <= 1'b1;
        end
    end

    // Payload storage carries no reset; valid_reg qualifies every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= bus.st_addr;
            data_mem[wr_ptr_reg] <= bus.st_data;
        end
    end

    assign bus.st_ready         = !full;
    assign bus.empty            = is_empty;
    assign bus.count            = count_reg;
    assign bus.dm_write         = pop;
    assign bus.dm_write_address = is_empty ? '0 : addr_mem[rd_ptr_reg];
    assign bus.dm_write_data    = is_empty ? '0 : data_mem[rd_ptr_reg];

    // Lookup ordered by age: slot gi is the (gi+1)-th most recent store.
    logic [DEPTH-1:0]  match_age;
    logic [DATA_W-1:0] age_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] age_idx;
            assign age_idx       = wr_ptr_reg - PTR_W'(gi + 1);
            assign match_age[gi] = valid_reg[age_idx] &&
                                   (((addr_mem[age_idx] ^ bus.ld_addr) & WORD_MASK) == '0);
            assign age_data[gi]  = data_mem[age_idx];
        end
    endgenerate

    logic              any_match;
    logic [DATA_W-1:0] youngest_data;

    always_comb begin
        youngest_data = '0;
        // Walk oldest to youngest so the youngest match is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_age[i])
                youngest_data = age_data[i];
        end
    end

    assign any_match = bus.ld_en && (|match_age);

`ifdef STORE_BUF_FWD_EN
    assign bus.ld_hit   = any_match;
    assign bus.ld_data  = any_match ? youngest_data : '0;
    assign bus.ld_stall = 1'b0;
`else
    assign bus.ld_hit   = 1'b0;
    assign bus.ld_data  = '0;
    assign bus.ld_stall = any_match;
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboarded bench for mem_store_buffer: expected memory writes are queued at store
// acceptance and popped when the buffer drains; load results come from the same queue.
module tb_mem_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs against the model, then advance to the next negedge.
    task automatic cycle();
        entry_t e;
        bit m;
        logic [DATA_W-1:0] exp_ld;
        int n;
        #1;
        n = sb.size();
        check_val("st_ready", bus.st_ready, n != DEPTH);
        check_val("count", bus.count, n);
        check_val("empty", bus.empty, n == 0);
        m = 0;
        exp_ld = '0;
        if (bus.ld_en) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (sb[i].addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]) begin
                    m = 1;
                    exp_ld = sb[i].data;
                    break;
                end
            end
        end
`ifdef STORE_BUF_FWD_EN
        check_val("ld_hit", bus.ld_hit, m);
        check_val("ld_data", bus.ld_data, exp_ld);
        check_val("ld_stall", bus.ld_stall, 0);
`else
        check_val("ld_hit", bus.ld_hit, 0);
        check_val("ld_data", bus.ld_data, 0);
        check_val("ld_stall", bus.ld_stall, m);
`endif
        if (bus.ld_en)
            $display("load addr=%h hit=%0b stall=%0b data=%h", bus.ld_addr, bus.ld_hit,
                     bus.ld_stall, bus.ld_data);
        check_val("dm_write", bus.dm_write, (n != 0) && bus.dm_grant);
        if (n != 0 && bus.dm_grant) begin
            e = sb.pop_front();
            check_val("dm_addr", bus.dm_write_address, e.addr);
            check_val("dm_data", bus.dm_write_data, e.data);
            $display("write addr=%h data=%h", bus.dm_write_address, bus.dm_write_data);
        end else if (n == 0) begin
            check_val("dm_addr_idle", bus.dm_write_address, 0);
            check_val("dm_data_idle", bus.dm_write_data, 0);
        end
        if (bus.st_valid && n != DEPTH) begin
            e.addr = bus.st_addr;
            e.data = bus.st_data;
            sb.push_back(e);
            $display("store addr=%h data=%h", e.addr, e.data);
        end
        @(negedge clk);
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit acc;
        acc = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        for (int k = 0; k < 40; k++) begin
            acc = (sb.size() != DEPTH);
            cycle();
            if (acc) break;
        end
        if (!acc) check_val("store_timeout", 0, 1);
        bus.st_valid = 1'b0;
    endtask

    task automatic drain();
        bus.dm_grant = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        check_val("drain_done", sb.size(), 0);
        check_val("drain_empty", bus.empty, 1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.dm_grant = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cycle();

        // Reset with three entries held
        store(32'h0000_0100, 32'h1111_0001);
        store(32'h0000_0104, 32'h1111_0002);
        store(32'h0000_0108, 32'h1111_0003);
        check_val("pre_reset_count", bus.count, 3);
        bus.dm_grant = 1'b1;
        reset = 1'b1;
        #1;
        sb.delete();
        check_val("rst_count", bus.count, 0);
        check_val("rst_empty", bus.empty, 1);
        check_val("rst_dm_write", bus.dm_write, 0);
        check_val("rst_st_ready", bus.st_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        bus.dm_grant = 1'b0;
        cycle();

        // Fill to DEPTH, hold a fifth store, then drain in order
        for (int i = 0; i < 4; i++)
            store(32'h10 + 32'(4 * i), 32'hD000_0000 + 32'(i));
        check_val("full_count", bus.count, 4);
        check_val("full_ready", bus.st_ready, 0);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h30;
        bus.st_data  = 32'hD000_0005;
        cycle();
        bus.dm_grant = 1'b1;
        cycle();
        check_val("pop_only_count", bus.count, 3);
        check_val("pop_only_ready", bus.st_ready, 1);
        cycle();
        bus.st_valid = 1'b0;
        drain();

        // Two stores to the same word, then a load with a different byte offset
        bus.dm_grant = 1'b0;
        store(32'h20, 32'hAAAA_0000);
        store(32'h20, 32'hBBBB_0000);
        bus.ld_addr = 32'h22;
        cycle();
        bus.ld_en = 1'b1;
        cycle();
        bus.ld_addr = 32'h24;
        cycle();
        bus.ld_addr = 32'h22;
        bus.dm_grant = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        cycle();
        bus.ld_en = 1'b0;

        // Pointer wrap with grant toggling
        for (int i = 0; i < 10; i++) begin
            bus.dm_grant = (i % 3) != 0;
            store(32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        end
        drain();

        // Store and load to the same word in the same cycle
        bus.dm_grant = 1'b0;
        bus.ld_en    = 1'b1;
        bus.ld_addr  = 32'h40;
        store(32'h40, 32'h4040_4040);
        cycle();
        bus.ld_en = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end
endmodule
